pc_sequencer: RTL

- Upstream neighbour of the fetch stage in the enable-chained, one-instruction-in-flight core.
- Holds the architectural next PC and issues a one-cycle fetch enable with that PC to fetch.
- Waits for the writeback-done pulse of the in-flight instruction, then selects the following PC: sequential, branch, jump or halt.
- Also counts retired instructions and flags handshake protocol errors.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control, fetch-issue and status bundle for pc_sequencer
interface pc_sequencer_if #(
    parameter int PC_W = 19
);
    logic            start;
    logic            stall;
    logic            wb_done;
    logic            halt;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            fetch_en;
    logic [PC_W-1:0] nextpc;
    logic            busy;
    logic            halted;
    logic [31:0]     retired;
    logic            err;

    modport master (
        input  start, stall, wb_done, halt, jump, jump_target, branch_taken, branch_target,
        output fetch_en, nextpc, busy, halted, retired, err
    );

    modport slave (
        output start, stall, wb_done, halt, jump, jump_target, branch_taken, branch_target,
        input  fetch_en, nextpc, busy, halted, retired, err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC holder issuing one fetch per retired instruction
module pc_sequencer #(
    parameter int PC_W     = 19,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 1
) (
    input  logic           clk,
    input  logic           rstn,
    pc_sequencer_if.master bus
);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] STEP   = PC_W'(PC_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALTED} state_t;

    state_t          state;
    logic            fetch_en_q;
    logic [PC_W-1:0] nextpc_q;
    logic            busy_q;
    logic            halted_q;
    logic [31:0]     retired_q;
    logic            err_q;
    logic            wb_bad;
    logic            wb_ok;

    // A completion pulse is only legitimate in WAIT after the issue cycle has passed.
    assign wb_bad = bus.wb_done && ((state != S_WAIT) || fetch_en_q);
    assign wb_ok  = bus.wb_done && (state == S_WAIT) && !fetch_en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            fetch_en_q <= 1'b0;
            nextpc_q   <= RST_PC;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            fetch_en_q <= 1'b0;
            if (wb_bad) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        state     <= S_ISSUE;
                        nextpc_q  <= RST_PC;
                        retired_q <= 32'd0;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (!bus.stall) begin
                        fetch_en_q <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wb_ok) begin
                        retired_q <= retired_q + 32'd1;
                        if (bus.halt) begin
                            state    <= S_HALTED;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                            if (bus.jump) begin
                                nextpc_q <= bus.jump_target;
                            end else if (bus.branch_taken) begin
                                nextpc_q <= bus.branch_target;
                            end else begin
                                nextpc_q <= nextpc_q + STEP;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.fetch_en = fetch_en_q;
    assign bus.nextpc   = nextpc_q;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;
    assign bus.retired  = retired_q;
    assign bus.err      = err_q;
endmodule
